pattern_detector_param: RTL and testbench
=========================================

// Module: pattern_detector_param
// PURPOSE
//  Parametrised, runtime-programmable serial bit-pattern detector; generalises the fixed "11" detector.
//  Detects a pattern of 1..MAX_LEN bits on serial input w, qualified by w_valid.
//  Supports overlapping and non-overlapping match modes, and keeps a saturating match counter.
//  Sits on serial FSM-lab datapaths as a drop-in for hard-coded sequence detectors.
// PARAMETERS
//  MAX_LEN          8         longest supported pattern, in bits (>=2)
//  LEN_W            4         width of cfg_len; must hold MAX_LEN ($clog2(MAX_LEN+1))
//  CNT_W            16        width of match_count
//  DEFAULT_PATTERN  8'h03     pattern loaded at reset (MAX_LEN bits)
//  DEFAULT_LEN      2         pattern length loaded at reset
//  DEFAULT_OVERLAP  1'b1      match mode loaded at reset; 1 = overlapping
// PORTS
//  clk          in   1        single clock; all state changes on posedge
//  reset        in   1        asynchronous, active-high reset
//  en           in   1        detector enable; 0 forces IDLE
//  w_valid      in   1        w is sampled only when this is 1
//  w            in   1        serial data bit
//  cfg_load     in   1        1-cycle strobe; latch cfg_* and restart detection
//  cfg_pattern  in   MAX_LEN  pattern; bit len-1 = first bit received, bit 0 = last
//  cfg_len      in   LEN_W    pattern length
//  cfg_overlap  in   1        1 = overlapping matches, 0 = non-overlapping
//  clr_count    in   1        1-cycle strobe; clears match_count and cnt_sat
//  z            out  1        registered 1-cycle match pulse
//  match_count  out  CNT_W    saturating count of matches
//  cnt_sat      out  1        sticky flag: match_count reached all-ones
//  armed        out  1        1 when in state ARMED (history holds len valid bits)
// BEHAVIOUR
//  Reset (async): state=IDLE; hist=0; fill=0; pattern/len/overlap=DEFAULT_*; z=0; match_count=0; cnt_sat=0; armed=0.
//  Config:
//   - cfg_len==0 is stored as 1; cfg_len>MAX_LEN is stored as MAX_LEN.
//   - mask = low len bits set.
//  Config load:
//   - cfg_load=1 latches the config and sets hist=0, fill=0.
//   - Next state is FILL if en=1, else IDLE.
//   - cfg_load has priority over w_valid in the same cycle; that bit is dropped and z=0 next cycle.
//  Sampling (w_valid=1, en=1, no cfg_load):
//   - hist_n = {hist[MAX_LEN-2:0], w}; fill_n = min(fill+1, len).
//   - match = (fill_n==len) && (((hist_n ^ pattern) & mask)==0).
//  Latency: z=1 in exactly the cycle after the edge that samples the final pattern bit; z=0 in every other cycle.
//  Cycles with w_valid=0 hold hist, fill and state unchanged, and give z=0 next cycle.
//  FSM (3 states):
//   - IDLE: en=0. w ignored; hist and fill cleared. en=1 -> FILL.
//   - FILL: fill<len. Sample; if fill_n==len: on match with overlap=0 -> FILL with fill=0; otherwise -> ARMED.
//   - ARMED: fill==len.
//     - overlap=1: every sample is checked; stay in ARMED.
//     - overlap=0: a match sets fill=0 -> FILL; a non-match stays in ARMED.
//   - en=0 in any state -> IDLE next cycle; z=0.
//   - Reset mid-pattern discards all partial progress.
//  Counter:
//   - On match, match_count increments unless it is all-ones; it holds at all-ones, and cnt_sat sets when the count reaches all-ones.
//   - clr_count together with a match gives match_count=1; cnt_sat is cleared.
//   - match_count and cnt_sat update in the same cycle as z.
//  Width rules: all compares are masked to len bits; hist bits above len are don't-care; no truncation warnings permitted.
// STRUCTURE
//  Package seqdet_pkg:
//   - ST_IDLE=2'b00, ST_FILL=2'b01, ST_ARMED=2'b10;
//   - function clamp_len(cfg_len, MAX_LEN); function len_mask(len).
//  Sub-module seq_match_counter (CNT_W): saturating counter with inc, clr, count, sat. Reused by other detectors.
//  Top level: config registers, history shift register plus fill counter, FSM, compare logic, z register.
// TESTING
//  1. Defaults, en=1, w_valid=1, w=0,1,1,1,0 -> z=0,0,0,1,1,0 (z lags the sampled bit by one cycle); match_count=2.
//  2. Load pattern 4'b1011, len 4, overlap=0; stream 1011011 -> one z pulse; count=1.
//     Same stream with overlap=1 -> two pulses; count=2.
//  3. Pattern 101 with gaps: w_valid=0 cycles inserted between 1,0,1 -> still one z; z=0 during the gaps.
//  4. cfg_len=0 -> behaves as len 1; cfg_len=15 -> behaves as len 8.
//     cfg_load in the same cycle as w_valid -> bit dropped, z=0.
//  5. CNT_W=3, 9 matches -> count holds at 7 and cnt_sat=1.
//     clr_count together with a match -> count=1, cnt_sat=0.
//  6. Async reset asserted mid-pattern (2 of 3 bits seen) -> all outputs reset immediately.
//     After release, the remaining bit alone does not match; en=0 then 1 also discards a partial pattern.

Source files
------------

// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared state encoding and config helpers for serial sequence detectors
package seqdet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_ARMED = 2'b10
    } state_t;

    // Out-of-range lengths are folded into 1..max_len so the fill counter always terminates.
    function automatic int unsigned clamp_len(input int unsigned cfg_len, input int unsigned max_len);
        int unsigned r;
        if (cfg_len == 0) begin
            r = 1;
        end else if (cfg_len > max_len) begin
            r = max_len;
        end else begin
            r = cfg_len;
        end
        return r;
    endfunction

    function automatic logic [31:0] len_mask(input int unsigned len);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with sticky saturation flag
module seq_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            // A clear coinciding with a match keeps that match.
            count_d = inc ? ONE : '0;
            sat_d   = 1'b0;
        end else if (inc) begin
            if (count_q != ALL_ONES) begin
                count_d = count_q + ONE;
            end
            sat_d = sat_q | (count_d == ALL_ONES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/pattern_detector_param.sv
// rtl/pattern_detector_param.sv - runtime-programmable serial bit-pattern detector
module pattern_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 MAX_LEN         = 8,
    parameter int                 LEN_W           = 4,
    parameter int                 CNT_W           = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 'h03,
    parameter int                 DEFAULT_LEN     = 2,
    parameter logic               DEFAULT_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               w_valid,
    input  logic               w,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat,
    output logic               armed
);

    localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               z_q, z_d;
    logic               match;

    always_comb begin
        hist_n = {hist_q[MAX_LEN-2:0], w};
        fill_n = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match   = 1'b0;

        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = en ? ST_FILL : ST_IDLE;
        end else if (!en) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_IDLE;
        end else begin
            // IDLE with en high behaves as FILL from an empty history.
            if (state_q == ST_IDLE) begin
                state_d = ST_FILL;
            end
            if (w_valid) begin
                hist_d = hist_n;
                fill_d = fill_n;
                match  = (fill_n == len_q) &&
                         (((32'(hist_n) ^ 32'(pat_q)) & len_mask(32'(len_q))) == 32'd0);
                if (fill_n == len_q) begin
                    if (match && !ovl_q) begin
                        fill_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
        end
        z_d = match;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEFAULT_PATTERN;
            len_q   <= RST_LEN;
            ovl_q   <= DEFAULT_OVERLAP;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            z_q     <= z_d;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clr_count),
        .count (match_count),
        .sat   (cnt_sat)
    );

    assign z     = z_q;
    assign armed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb/tb_pattern_detector_param.sv - self-checking bench for pattern_detector_param
module tb_pattern_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               w_valid;
    logic               w;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cnt_sat;
    logic               armed;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_q[$];

    typedef struct {
        logic v;
        logic b;
        logic ez;
    } vec_t;

    pattern_detector_param #(
        .MAX_LEN         (MAX_LEN),
        .LEN_W           (LEN_W),
        .CNT_W           (CNT_W),
        .DEFAULT_PATTERN (8'h03),
        .DEFAULT_LEN     (2),
        .DEFAULT_OVERLAP (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .w_valid     (w_valid),
        .w           (w),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clr_count   (clr_count),
        .z           (z),
        .match_count (match_count),
        .cnt_sat     (cnt_sat),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic pop_z(input string nm);
        logic ez;
        if (exp_q.size() == 0) begin
            chk({nm, " scoreboard empty"}, 1, 0);
        end else begin
            ez = exp_q.pop_front();
            chk(nm, int'(z), int'(ez));
        end
    endtask

    task automatic cyc(input logic v, input logic b, input logic ez, input string nm);
        @(negedge clk);
        w_valid = v;
        w       = b;
        exp_q.push_back(ez);
        @(posedge clk);
        #1;
        pop_z(nm);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o,
                        input logic v, input logic b, input string nm);
        @(negedge clk);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        w_valid     = v;
        w           = b;
        exp_q.push_back(1'b0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        w_valid  = 1'b0;
        pop_z(nm);
    endtask

    task automatic clr();
        @(negedge clk);
        clr_count = 1'b1;
        w_valid   = 1'b0;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        chk("clr count", int'(match_count), 0);
    endtask

    initial begin
        vec_t t1[5];
        vec_t t2[7];
        logic [6:0] s2;
        logic [7:0] pa5;

        t1[0] = '{1'b1, 1'b0, 1'b0};
        t1[1] = '{1'b1, 1'b1, 1'b0};
        t1[2] = '{1'b1, 1'b1, 1'b1};
        t1[3] = '{1'b1, 1'b1, 1'b1};
        t1[4] = '{1'b1, 1'b0, 1'b0};

        reset = 1'b1; en = 1'b0; w_valid = 1'b0; w = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
        #12;
        chk("reset z", int'(z), 0);
        chk("reset count", int'(match_count), 0);
        chk("reset sat", int'(cnt_sat), 0);
        chk("reset armed", int'(armed), 0);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;

        // Default "11" overlapping detector.
        for (int i = 0; i < 5; i++) begin
            cyc(t1[i].v, t1[i].b, t1[i].ez, $sformatf("t1 z[%0d]", i));
        end
        chk("t1 count", int'(match_count), 2);
        chk("t1 armed", int'(armed), 1);

        // 1011 over stream 1011011, non-overlapping then overlapping.
        s2 = 7'b1011011;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 7; i++) begin
                t2[i].v  = 1'b1;
                t2[i].b  = s2[6-i];
                t2[i].ez = (i == 3) || (m == 1 && i == 6);
            end
            load(8'b0000_1011, 4'd4, m[0], 1'b0, 1'b0, "t2 load");
            clr();
            for (int i = 0; i < 7; i++) begin
                cyc(t2[i].v, t2[i].b, t2[i].ez, $sformatf("t2 ovl%0d z[%0d]", m, i));
            end
            chk($sformatf("t2 ovl%0d count", m), int'(match_count), m + 1);
        end

        // 101 with w_valid gaps carrying junk bits.
        load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, "t3 load");
        cyc(1'b1, 1'b1, 1'b0, "t3 b0");
        cyc(1'b0, 1'b0, 1'b0, "t3 gap0");
        cyc(1'b0, 1'b1, 1'b0, "t3 gap1");
        cyc(1'b1, 1'b0, 1'b0, "t3 b1");
        cyc(1'b0, 1'b1, 1'b0, "t3 gap2");
        cyc(1'b1, 1'b1, 1'b1, "t3 b2");

        // cfg_len 0 acts as length 1; upper pattern bits must be masked.
        load(8'hFE, 4'd0, 1'b1, 1'b0, 1'b0, "t4 load0");
        cyc(1'b1, 1'b0, 1'b1, "t4 len1 a");
        cyc(1'b1, 1'b1, 1'b0, "t4 len1 b");
        cyc(1'b1, 1'b0, 1'b1, "t4 len1 c");
        // A bit arriving with cfg_load is dropped.
        load(8'hFE, 4'd0, 1'b1, 1'b1, 1'b0, "t4 drop");
        cyc(1'b1, 1'b0, 1'b1, "t4 after drop");

        // cfg_len 15 acts as length 8.
        load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, "t4 load15");
        pa5 = 8'hA5;
        for (int i = 6; i >= 0; i--) begin
            cyc(1'b1, pa5[i], 1'b0, $sformatf("t4 pre[%0d]", i));
        end
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b1, pa5[i], (i == 0), $sformatf("t4 len8[%0d]", i));
        end

        // Saturation with a 3-bit counter.
        load(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, "t5 load");
        clr();
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b1, 1'b1, $sformatf("t5 z[%0d]", i));
            chk($sformatf("t5 count[%0d]", i), int'(match_count), (i > 7) ? 7 : i);
            chk($sformatf("t5 sat[%0d]", i), int'(cnt_sat), (i >= 7) ? 1 : 0);
        end
        clr_count = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, "t5 clr+match z");
        clr_count = 1'b0;
        chk("t5 clr+match count", int'(match_count), 1);
        chk("t5 clr+match sat", int'(cnt_sat), 0);

        // Async reset mid-pattern.
        load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, "t6 load");
        cyc(1'b1, 1'b1, 1'b0, "t6 b0");
        cyc(1'b1, 1'b0, 1'b0, "t6 b1");
        #3;
        reset = 1'b1;
        #1;
        chk("t6 rst count", int'(match_count), 0);
        chk("t6 rst z", int'(z), 0);
        chk("t6 rst armed", int'(armed), 0);
        @(negedge clk);
        reset = 1'b0;
        load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, "t6 reload");
        cyc(1'b1, 1'b1, 1'b0, "t6 tail bit");
        chk("t6 tail count", int'(match_count), 0);

        // en low discards a partial pattern.
        load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, "t6 load en");
        cyc(1'b1, 1'b1, 1'b0, "t6e b0");
        cyc(1'b1, 1'b0, 1'b0, "t6e b1");
        en = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, "t6e en0");
        chk("t6e idle armed", int'(armed), 0);
        en = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, "t6e tail");
        cyc(1'b1, 1'b0, 1'b0, "t6e r1");
        cyc(1'b1, 1'b1, 1'b1, "t6e r2");
        chk("t6e armed", int'(armed), 1);
        chk("t6e count", int'(match_count), 1);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
